// File: rtl/sram_bridge_if.sv
// ---------------------------------------------------------------------------
// sram_bridge_if
//   Request/handshake bundle between the direct-mapped cache (master) and the
//   SRAM bridge (slave). The 32-bit data bus is bidirectional and is carried
//   as a separate inout port on the bridge so that it can be tri-stated.
//
//   read_mem   : read request, held until ready_mem is seen
//   write_mem  : write request, held until ready_mem is seen
//   mem_be     : write byte enables, bit 3 = data[31:24]
//   mem_adbus  : byte address
//   grant_mem  : request accepted, high from grant until the request drops
//   ready_mem  : transaction complete (read data valid on the data bus)
// ---------------------------------------------------------------------------
interface sram_bridge_if;
  logic        read_mem;
  logic        write_mem;
  logic [3:0]  mem_be;
  logic [31:0] mem_adbus;
  logic        grant_mem;
  logic        ready_mem;

  modport master (
    output read_mem, write_mem, mem_be, mem_adbus,
    input  grant_mem, ready_mem
  );

  modport slave (
    input  read_mem, write_mem, mem_be, mem_adbus,
    output grant_mem, ready_mem
  );
endinterface

// File: rtl/sram_bridge.sv
// ---------------------------------------------------------------------------
// sram_bridge
//   Memory-side slave below the direct-mapped cache. Each cache request is
//   carried out as a single 32-bit access to an asynchronous SRAM with
//   active-low controls and per-byte enables. One transaction at a time; all
//   SRAM control outputs are registered.
//
//   Parameters
//     ADDR_W      : SRAM word-address width (address = mem_adbus[ADDR_W+1:2])
//     WAIT_CYCLES : cycles of oe_n low (read) / we_n low (write), 1..15
//
//   Ports
//     clk, reset  : clock (rising edge) and synchronous active-high reset
//     bus         : cache-side request/handshake bundle (slave modport)
//     mem_databus : write data in; read data out while ready_mem on a read
//     sram_addr   : SRAM word address
//     sram_data   : SRAM data bus, driven only during the write sequence
//     sram_ce_n, sram_oe_n, sram_we_n, sram_be_n : SRAM controls, active-low
// ---------------------------------------------------------------------------
module sram_bridge #(
  parameter int ADDR_W      = 18,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  sram_bridge_if.slave      bus,
  inout  wire  [31:0]       mem_databus,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [31:0]       sram_data,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [3:0]        sram_be_n
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_GRANT    = 3'd1;
  localparam logic [2:0] S_RD       = 3'd2;
  localparam logic [2:0] S_WR_SETUP = 3'd3;
  localparam logic [2:0] S_WR_PULSE = 3'd4;
  localparam logic [2:0] S_WR_HOLD  = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  // Counter runs WAIT_CYCLES-1 .. 0, so the strobe lasts WAIT_CYCLES cycles.
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  logic [2:0]  state;
  logic [3:0]  cnt;
  logic        is_write;
  logic        sram_drive;   // bridge owns sram_data
  logic        bus_drive;    // bridge owns mem_databus
  logic        grant_q;
  logic        ready_q;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        req;

  assign req           = bus.read_mem | bus.write_mem;
  assign bus.grant_mem = grant_q;
  assign bus.ready_mem = ready_q;

  assign sram_data   = sram_drive ? wr_data : 'z;
  assign mem_databus = bus_drive  ? rd_data : 'z;

  // Address bits outside the SRAM word range are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.mem_adbus[31:ADDR_W+2], bus.mem_adbus[1:0]};

  // NOTE: every register below is sequential state, so it is written with
  // non-blocking assignments only; a blocking write here would let later
  // statements in the same block see the new value and skew the pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      is_write   <= 1'b0;
      grant_q    <= 1'b0;
      ready_q    <= 1'b0;
      sram_drive <= 1'b0;
      bus_drive  <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_be_n  <= 4'b1111;
      sram_addr  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            state    <= S_GRANT;
            grant_q  <= 1'b1;
            // A simultaneous read+write request resolves to the write.
            is_write <= bus.write_mem;
          end
        end

        S_GRANT: begin
          // Requester drives address/data/be during GRANT; take them now and
          // never look at the requester bus again for this transaction.
          sram_addr <= bus.mem_adbus[ADDR_W+1:2];
          sram_ce_n <= 1'b0;
          if (is_write) begin
            state      <= S_WR_SETUP;
            sram_be_n  <= ~bus.mem_be;
            sram_drive <= 1'b1;
          end else begin
            state     <= S_RD;
            sram_oe_n <= 1'b0;
            sram_be_n <= 4'b0000;
            cnt       <= CNT_LOAD;
          end
        end

        S_RD: begin
          if (cnt == 4'd0) begin
            state     <= S_DONE;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_be_n <= 4'b1111;
            ready_q   <= 1'b1;
            bus_drive <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        S_WR_SETUP: begin
          // Address, data and byte enables have been stable for a full cycle.
          state     <= S_WR_PULSE;
          sram_we_n <= 1'b0;
          cnt       <= CNT_LOAD;
        end

        S_WR_PULSE: begin
          if (cnt == 4'd0) begin
            state     <= S_WR_HOLD;
            sram_we_n <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        S_WR_HOLD: begin
          // Data and address stay on the pins for one cycle after we_n rises.
          state      <= S_DONE;
          sram_ce_n  <= 1'b1;
          sram_be_n  <= 4'b1111;
          sram_drive <= 1'b0;
          ready_q    <= 1'b1;
        end

        S_DONE: begin
          if (!req) begin
            state     <= S_IDLE;
            grant_q   <= 1'b0;
            ready_q   <= 1'b0;
            bus_drive <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: pure datapath registers carry no reset; their contents are only
  // observed after the FSM has loaded them, and leaving them out of reset
  // keeps the reset net off the 64 data flops.
  always_ff @(posedge clk) begin
    if (state == S_GRANT)
      wr_data <= mem_databus;
    if (state == S_RD && cnt == 4'd0)
      rd_data <= sram_data;
  end

endmodule

// File: tb/tb_sram_bridge.sv
// ---------------------------------------------------------------------------
// tb_sram_bridge
//   Self-checking bench for sram_bridge. Two instances are built: one with
//   WAIT_CYCLES=2 (default) and one with WAIT_CYCLES=1; 'sel' picks which one
//   the stimulus drives and which one is observed. Each instance has its own
//   asynchronous SRAM model sharing one storage array. Expected results come
//   from a word-level reference memory plus the latency rule
//   (read: T0+1+W edges, write: T0+3+W edges).
// ---------------------------------------------------------------------------
module tb_sram_bridge;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Stimulus registers (shared, routed to the selected instance)
  logic        sel = 1'b0;
  logic        rd_r = 1'b0, wr_r = 1'b0, db_en = 1'b0, probe = 1'b0;
  logic [3:0]  be_r = 4'h0;
  logic [31:0] ad_r = 32'h0, db_drv = 32'h0;

  logic [31:0] sram_mem [0:262143];
  logic [31:0] ref_mem [int];

  sram_bridge_if bif0 ();
  sram_bridge_if bif1 ();

  wire  [31:0] mdb0, mdb1, sd0, sd1;
  logic [17:0] addr0, addr1;
  logic        ce0, oe0, we0, ce1, oe1, we1;
  logic [3:0]  ben0, ben1;

  assign bif0.read_mem  = rd_r & ~sel;
  assign bif0.write_mem = wr_r & ~sel;
  assign bif0.mem_be    = be_r;
  assign bif0.mem_adbus = ad_r;
  assign bif1.read_mem  = rd_r & sel;
  assign bif1.write_mem = wr_r & sel;
  assign bif1.mem_be    = be_r;
  assign bif1.mem_adbus = ad_r;

  assign mdb0 = (db_en && !sel) ? db_drv : 'z;
  assign mdb1 = (db_en &&  sel) ? db_drv : 'z;

  // Asynchronous SRAM: drives on ce_n=oe_n=0; the probe drives zero so a
  // released bus reads back 0 and any stray driver shows up as non-zero.
  assign sd0 = (!ce0 && !oe0) ? sram_mem[addr0] : ((probe && !sel) ? 32'h0 : 'z);
  assign sd1 = (!ce1 && !oe1) ? sram_mem[addr1] : ((probe &&  sel) ? 32'h0 : 'z);

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    for (int i = 0; i < 4; i++)
      if (be[i]) old_w[8*i +: 8] = new_w[8*i +: 8];
    return old_w;
  endfunction

  always @(posedge we0) if (ce0 === 1'b0) sram_mem[addr0] = merge(sram_mem[addr0], sd0, ~ben0);
  always @(posedge we1) if (ce1 === 1'b0) sram_mem[addr1] = merge(sram_mem[addr1], sd1, ~ben1);

  sram_bridge #(.ADDR_W(18), .WAIT_CYCLES(2)) u_dut0 (
    .clk(clk), .reset(reset), .bus(bif0), .mem_databus(mdb0), .sram_addr(addr0),
    .sram_data(sd0), .sram_ce_n(ce0), .sram_oe_n(oe0), .sram_we_n(we0), .sram_be_n(ben0)
  );

  sram_bridge #(.ADDR_W(18), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(bif1), .mem_databus(mdb1), .sram_addr(addr1),
    .sram_data(sd1), .sram_ce_n(ce1), .sram_oe_n(oe1), .sram_we_n(we1), .sram_be_n(ben1)
  );

  // Observed view of the selected instance
  wire        grant_o = sel ? bif1.grant_mem : bif0.grant_mem;
  wire        ready_o = sel ? bif1.ready_mem : bif0.ready_mem;
  wire [31:0] mdb_o   = sel ? mdb1 : mdb0;
  wire [31:0] sdata_o = sel ? sd1 : sd0;
  wire [17:0] saddr_o = sel ? addr1 : addr0;
  wire        ce_o    = sel ? ce1 : ce0;
  wire        oe_o    = sel ? oe1 : oe0;
  wire        we_o    = sel ? we1 : we0;
  wire [3:0]  ben_o   = sel ? ben1 : ben0;

  function automatic logic [31:0] ref_rd(input int idx);
    return ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
  endfunction

  task automatic preload(input int idx, input logic [31:0] val);
    sram_mem[idx] = val;
    ref_mem[idx]  = val;
  endtask

  // One complete transaction; entered and left away from the rising edge.
  task automatic do_txn(input bit wr, input bit rd_also, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] be_v,
                        input int hold, input string tag);
    int w, k, oe_cnt, we_cnt, wph, idx, lat;
    bit got;
    logic [31:0] exp_w;
    w      = sel ? 1 : 2;
    idx    = int'(addr[19:2]);
    exp_w  = wr ? merge(ref_rd(idx), data, be_v) : ref_rd(idx);
    lat    = wr ? w + 3 : w + 1;
    oe_cnt = 0; we_cnt = 0; wph = 0; k = 0; got = 1'b0;

    wr_r = wr; rd_r = !wr || rd_also; ad_r = addr; be_r = be_v; db_drv = data; db_en = wr;
    @(posedge clk); @(negedge clk);  // T0
    checks++;
    if (grant_o !== 1'b1 || ready_o !== 1'b0) begin
      errors++;
      $display("FAIL %s grant_after_T0: grant=%b ready=%b, want 1/0", tag, grant_o, ready_o);
    end

    while (!got && k < 40) begin
      @(posedge clk); @(negedge clk); k++;
      if (!ce_o) begin
        checks++;
        if (saddr_o !== addr[19:2]) begin
          errors++;
          $display("FAIL %s sram_addr k=%0d: got %h want %h", tag, k, saddr_o, addr[19:2]);
        end
      end
      if (!ce_o && !oe_o) begin
        oe_cnt++; checks++;
        if (sdata_o !== exp_w || ben_o !== 4'b0000) begin
          errors++;
          $display("FAIL %s read_phase k=%0d: data=%h be_n=%b want %h/0000", tag, k, sdata_o, ben_o, exp_w);
        end
      end
      if (!ce_o && oe_o) begin
        wph++; checks++;
        if (sdata_o !== data || ben_o !== ~be_v) begin
          errors++;
          $display("FAIL %s write_phase k=%0d: data=%h be_n=%b want %h/%b", tag, k, sdata_o, ben_o, data, ~be_v);
        end
      end
      checks++;
      if (!oe_o && !we_o) begin
        errors++;
        $display("FAIL %s contention k=%0d: oe_n=%b we_n=%b both low", tag, k, oe_o, we_o);
      end
      if (!we_o) we_cnt++;
      if (k == 1) begin  // requester bus goes stale after the latch edge
        ad_r = $urandom; be_r = 4'($urandom);
        if (wr) db_drv = $urandom;
      end
      got = (ready_o === 1'b1);
    end

    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s ready_timeout: no ready in %0d cycles", tag, k);
    end else if (k != lat) begin
      errors++;
      $display("FAIL %s latency: ready after edge T%0d, want T%0d", tag, k, lat);
    end
    checks++;
    if (oe_cnt != (wr ? 0 : w) || we_cnt != (wr ? w : 0) || wph != (wr ? w + 2 : 0)) begin
      errors++;
      $display("FAIL %s strobe_len: oe=%0d we=%0d wr_phase=%0d want %0d/%0d/%0d", tag, oe_cnt,
               we_cnt, wph, wr ? 0 : w, wr ? w : 0, wr ? w + 2 : 0);
    end
    if (!wr) begin
      checks++;
      if (mdb_o !== exp_w) begin
        errors++;
        $display("FAIL %s read_data: got %h want %h", tag, mdb_o, exp_w);
      end
    end

    for (int h = 0; h < hold; h++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (ready_o !== 1'b1 || grant_o !== 1'b1 || (!wr && mdb_o !== exp_w)) begin
        errors++;
        $display("FAIL %s done_hold: ready=%b grant=%b data=%h", tag, ready_o, grant_o, mdb_o);
      end
    end

    rd_r = 1'b0; wr_r = 1'b0; db_en = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (grant_o !== 1'b0 || ready_o !== 1'b0) begin
      errors++;
      $display("FAIL %s release: grant=%b ready=%b want 0/0", tag, grant_o, ready_o);
    end
    db_drv = 32'h0; db_en = 1'b1; #1;
    checks++;
    if (mdb_o !== 32'h0) begin
      errors++;
      $display("FAIL %s databus_released: got %h want 00000000", tag, mdb_o);
    end
    db_en = 1'b0;
    if (wr) begin
      ref_mem[idx] = exp_w;
      checks++;
      if (sram_mem[idx] !== exp_w) begin
        errors++;
        $display("FAIL %s sram_content: got %h want %h", tag, sram_mem[idx], exp_w);
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if (grant_o !== 1'b0 || ready_o !== 1'b0 || ce_o !== 1'b1 || oe_o !== 1'b1 ||
        we_o !== 1'b1 || ben_o !== 4'b1111 || saddr_o !== 18'h0) begin
      errors++;
      $display("FAIL %s reset_outputs: grant=%b ready=%b ce=%b oe=%b we=%b be=%b addr=%h",
               tag, grant_o, ready_o, ce_o, oe_o, we_o, ben_o, saddr_o);
    end
  endtask

  task automatic probe_buses(input string tag);
    probe = 1'b1; db_drv = 32'h0; db_en = 1'b1; #1;
    checks++;
    if (sdata_o !== 32'h0 || mdb_o !== 32'h0) begin
      errors++;
      $display("FAIL %s buses_hiz: sram_data=%h mem_databus=%h want both released", tag, sdata_o, mdb_o);
    end
    probe = 1'b0; db_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; rd_r = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      check_idle_outputs("reset");
    end
    probe_buses("reset");
    reset = 1'b0; rd_r = 1'b0;
  endtask

  task automatic test_read();
    preload(32'h40, 32'hDEADBEEF);
    do_txn(1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 1, "read");
  endtask

  task automatic test_full_write();
    do_txn(1'b1, 1'b0, 32'h0000_0200, 32'h1234_5678, 4'b1111, 0, "full_write");
    do_txn(1'b0, 1'b0, 32'h0000_0200, 32'h0, 4'h0, 0, "full_readback");
  endtask

  task automatic test_partial_write();
    preload(32'hC0, 32'h1122_3344);
    do_txn(1'b1, 1'b0, 32'h0000_0300, 32'hAABB_CCDD, 4'b0100, 0, "partial_write");
    do_txn(1'b0, 1'b0, 32'h0000_0300, 32'h0, 4'h0, 0, "partial_readback");
  endtask

  task automatic test_zero_be();
    preload(32'hD0, 32'h5A5A_0F0F);
    do_txn(1'b1, 1'b0, 32'h0000_0340, 32'hFFFF_FFFF, 4'b0000, 1, "zero_be_write");
    do_txn(1'b0, 1'b0, 32'h0000_0340, 32'h0, 4'h0, 0, "zero_be_readback");
  endtask

  task automatic test_reset_mid_write();
    int k;
    wr_r = 1'b1; ad_r = 32'h0000_0400; be_r = 4'hF; db_drv = 32'hCAFE_F00D; db_en = 1'b1;
    k = 0;
    while (we_o !== 1'b0 && k < 20) begin
      @(posedge clk); @(negedge clk); k++;
    end
    checks++;
    if (we_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_write_reach_pulse: we_n=%b after %0d cycles", we_o, k);
    end
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    wr_r = 1'b0; db_en = 1'b0;
    check_idle_outputs("mid_write");
    probe_buses("mid_write");
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (ready_o !== 1'b0 || grant_o !== 1'b0) begin
        errors++;
        $display("FAIL mid_write_no_ready: ready=%b grant=%b want 0/0", ready_o, grant_o);
      end
    end
    preload(32'h110, 32'h0BAD_F00D);
    do_txn(1'b0, 1'b0, 32'h0000_0440, 32'h0, 4'h0, 0, "after_abort_read");
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      bit          wr;
      logic [31:0] a;
      wr = 1'($urandom);
      a  = 32'h0000_4000 + 32'($urandom_range(0, 7)) * 4;
      do_txn(wr, 1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 2),
             $sformatf("rand%0d", i));
    end
  endtask

  task automatic test_back_to_back();
    sel = 1'b1;
    do_txn(1'b1, 1'b1, 32'h0000_0800, 32'h7654_3210, 4'b1111, 0, "rd_wr_both");
    preload(32'h201, 32'h0101_0101);
    preload(32'h202, 32'h0202_0202);
    do_txn(1'b0, 1'b0, 32'h0000_0800, 32'h0, 4'h0, 0, "b2b_rd0");
    do_txn(1'b0, 1'b0, 32'h0000_0804, 32'h0, 4'h0, 0, "b2b_rd1");
    do_txn(1'b0, 1'b0, 32'h0000_0808, 32'h0, 4'h0, 0, "b2b_rd2");
    sel = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 262144; i++) sram_mem[i] = 32'h0;
    reset = 1'b1;
    test_reset();
    test_read();
    test_full_write();
    test_partial_write();
    test_zero_be();
    test_reset_mid_write();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
